baud_gen_frac: RTL and testbench

Fractional-N, runtime-programmable baud tick generator for the UART system: the parametrised successor of the fixed-divisor tick counter. A divisor with integer and fractional parts is loaded through a valid/ready handshake and applied glitch-free on a tick boundary. From one accumulator it produces an oversample tick, a mid-bit sample tick and a bit tick. A resync input lets the receiver realign phase to a start-bit edge.

---
 rtl/baud_pkg.sv | 45 ++++
 rtl/baud_frac_div.sv | 78 +++++++
 rtl/baud_gen_frac.sv | 129 ++++++++++++
 tb/tb_baud_gen_frac.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
//
// Shared constants and types for the UART baud generation blocks.
//
// Contents:
//   BAUD_INT_W / BAUD_FRAC_W : default integer / fractional divisor widths
//   BAUD_OVS                 : default oversample ticks per bit
//   BAUD_CLK_HZ              : reference system clock the defaults assume
//   DEF_INT_* / DEF_FRAC_*   : divisor presets for common rates at 25 MHz
//   baud_div_t               : packed {div_int, div_frac} divisor pair
//   make_div()               : builds a baud_div_t from plain integers
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int BAUD_INT_W  = 16;
    localparam int BAUD_FRAC_W = 4;
    localparam int BAUD_OVS    = 16;
    localparam int BAUD_CLK_HZ = 25_000_000;

    // 25e6 / (115200 * 16) = 13.5634 -> 13 + 9/16
    localparam int DEF_INT_115200  = 13;
    localparam int DEF_FRAC_115200 = 9;

    // 25e6 / (9600 * 16) = 162.76 -> 162 + 12/16
    localparam int DEF_INT_9600  = 162;
    localparam int DEF_FRAC_9600 = 12;

    // Divisor as seen on the configuration port at the default widths.
    // The effective divide ratio is div_int + div_frac / 2^BAUD_FRAC_W.
    typedef struct packed {
        logic [BAUD_INT_W-1:0]  div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } baud_div_t;

    // Convenience constructor so callers can write make_div(13, 9)
    // instead of spelling out the packed literal with casts.
    function automatic baud_div_t make_div(input int i, input int f);
        baud_div_t d;
        d.div_int  = BAUD_INT_W'(i);
        d.div_frac = BAUD_FRAC_W'(f);
        return d;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// ---------------------------------------------------------------------------
// baud_frac_div
//
// Fractional-N divider core. A period counter runs to a limit of
// max(div_int,1) + carry, where carry is the overflow of a FRAC_W-bit
// phase accumulator that adds div_frac once per tick. Over 2^FRAC_W ticks
// the carry fires div_frac times, so the average tick period is
// div_int + div_frac/2^FRAC_W clock cycles.
//
// Ports:
//   clk      in  : system clock
//   reset    in  : synchronous active-high reset
//   en       in  : run enable; low holds all state and suppresses tick
//   clear    in  : restart phase (cnt, acc, carry -> 0), beats tick update
//   div_int  in  : integer part of the divisor (0 behaves as 1)
//   div_frac in  : fractional part of the divisor
//   tick     out : one-cycle tick, combinational from state and en
// ---------------------------------------------------------------------------
module baud_frac_div #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);

    logic [INT_W:0]   cnt;
    logic [FRAC_W-1:0] acc;
    logic             carry;

    logic [INT_W-1:0] eff_int;
    logic [INT_W:0]   limit;
    logic [INT_W:0]   last;
    logic [FRAC_W:0]  acc_sum;

    // Period limit is built one bit wider than the divisor so that the
    // largest integer divisor plus a carry cannot wrap. A zero divisor is
    // promoted to one, which gives a tick every enabled cycle.
    always_comb begin
        eff_int = (div_int == '0) ? INT_W'(1) : div_int;
        limit   = {1'b0, eff_int} + (INT_W+1)'(carry);
        last    = limit - (INT_W+1)'(1);
        acc_sum = {1'b0, acc} + {1'b0, div_frac};
    end

    // In normal running cnt never passes last, so this is a plain equality
    // test. The >= only matters if a smaller divisor is applied while the
    // core is disabled and cnt already sits beyond the new limit: the core
    // then ticks on the first enabled cycle instead of running the counter
    // all the way round its wide range.
    assign tick = en & (cnt >= last);

    // Counter and accumulator update. clear wins over everything except
    // reset, so a realignment always starts a clean period with no
    // pending carry. When disabled and not cleared, all state holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (tick) begin
            cnt          <= '0;
            {carry, acc} <= acc_sum;
        end else if (en) begin
            cnt <= cnt + (INT_W+1)'(1);
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_gen_frac
//
// Runtime-programmable fractional baud tick generator. A new divisor is
// accepted through a valid/ready handshake into a shadow register and
// copied to the active divisor only at a safe point (a tick, while
// disabled, or on resync), so a running period is never cut short or
// stretched by a reconfiguration. One divider core produces the oversample
// tick; an oversample index turns it into mid-bit and end-of-bit ticks.
//
// Ports:
//   clk       in  : system clock
//   reset     in  : synchronous active-high reset
//   en        in  : run enable; low freezes counters and suppresses ticks
//   resync    in  : one-cycle pulse restarting bit phase (works with en low)
//   cfg_valid in  : new divisor offered
//   cfg_ready out : shadow register free to accept a divisor
//   cfg_int   in  : integer divisor (0 treated as 1)
//   cfg_frac  in  : fractional divisor, in units of 1/2^FRAC_W
//   os_tick   out : oversample tick
//   mid_tick  out : oversample tick at index OVS/2-1 (RX sample point)
//   bit_tick  out : oversample tick at index OVS-1 (bit boundary)
// ---------------------------------------------------------------------------
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int INT_W    = BAUD_INT_W,
    parameter int FRAC_W   = BAUD_FRAC_W,
    parameter int OVS      = BAUD_OVS,
    parameter int DEF_INT  = DEF_INT_115200,
    parameter int DEF_FRAC = DEF_FRAC_115200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    localparam int IDX_W = $clog2(OVS);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVS - 1);

    // Local divisor type sized by this instance's parameters; the package
    // type is fixed at the default widths.
    typedef struct packed {
        logic [INT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } div_t;

    localparam div_t DIV_RESET = '{
        div_int:  INT_W'(DEF_INT),
        div_frac: FRAC_W'(DEF_FRAC)
    };

    div_t             act_div;
    div_t             shd_div;
    logic             pend;
    logic [IDX_W-1:0] os_idx;

    logic xfer;
    logic apply;

    // The shadow is free whenever nothing is waiting to be applied.
    assign cfg_ready = ~pend;
    assign xfer      = cfg_valid & cfg_ready;

    // Safe points for swapping the divisor: a tick boundary (cnt restarts
    // at zero), any cycle with the core frozen, or a resync (phase restarts
    // anyway). Because pend is registered, the swap can never happen on
    // the same edge that captured the shadow.
    assign apply = pend & (os_tick | ~en | resync);

    // Divider core; resync doubles as its phase clear.
    baud_frac_div #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (resync),
        .div_int  (act_div.div_int),
        .div_frac (act_div.div_frac),
        .tick     (os_tick)
    );

    // Configuration shadow and handshake. A transfer needs pend low and an
    // apply needs pend high, so the two branches are mutually exclusive.
    // Applying only swaps the divisor; the accumulator phase carries over
    // so the fractional error keeps averaging out across the change.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_div <= DIV_RESET;
            shd_div <= DIV_RESET;
            pend    <= 1'b0;
        end else if (apply) begin
            act_div <= shd_div;
            pend    <= 1'b0;
        end else if (xfer) begin
            shd_div <= '{div_int: cfg_int, div_frac: cfg_frac};
            pend    <= 1'b1;
        end
    end

    // Oversample index within the current bit. resync realigns it to the
    // start of a bit together with the divider phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            os_idx <= '0;
        end else if (resync) begin
            os_idx <= '0;
        end else if (os_tick) begin
            os_idx <= (os_idx == IDX_LAST) ? '0 : os_idx + IDX_W'(1);
        end
    end

    // Mid-bit and bit ticks are qualified copies of the oversample tick,
    // so they share its one-cycle width and its dependence on en.
    assign mid_tick = os_tick & (os_idx == IDX_MID);
    assign bit_tick = os_tick & (os_idx == IDX_LAST);

endmodule

// File: tb/tb_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// tb_baud_gen_frac
//
// Directed bench for baud_gen_frac built with a 4/0 reset divisor and 16x
// oversampling. Inputs change on the falling edge; outputs are sampled 1
// time unit later, so each sample belongs to the clock cycle that ends on
// the next rising edge. Cycle 1 is the first cycle with reset low and en
// high, matching how tick positions are numbered for this block.
// ---------------------------------------------------------------------------
module tb_baud_gen_frac;
    import baud_pkg::*;

    localparam int INT_W  = 16;
    localparam int FRAC_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              resync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    baud_div_t no_div;

    always #5 clk = ~clk;

    baud_gen_frac #(
        .INT_W    (INT_W),
        .FRAC_W   (FRAC_W),
        .OVS      (16),
        .DEF_INT  (4),
        .DEF_FRAC (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .resync    (resync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_int   (cfg_int),
        .cfg_frac  (cfg_frac),
        .os_tick   (os_tick),
        .mid_tick  (mid_tick),
        .bit_tick  (bit_tick)
    );

    // Drive one cycle's inputs on the falling edge and let them settle.
    task automatic applyStimulus(input logic e, input logic rs, input logic v,
                                 input baud_div_t d);
        @(negedge clk);
        en        = e;
        resync    = rs;
        cfg_valid = v;
        cfg_int   = d.div_int;
        cfg_frac  = d.div_frac;
        cyc++;
        #1;
    endtask

    // Single comparison point with failure accounting.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s (cycle %0d): observed %0d expected %0d",
                   tag, cyc, obs, exp);
        end
    endtask

    // Hold reset across two rising edges, check the reset state, then
    // release it with en low so the next applyStimulus call is cycle 1.
    task automatic resetDut();
        @(negedge clk);
        reset     = 1'b1;
        en        = 1'b0;
        resync    = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_frac  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset os_tick", os_tick, 0);
        checkOutput("reset mid_tick", mid_tick, 0);
        checkOutput("reset bit_tick", bit_tick, 0);
        checkOutput("reset cfg_ready", cfg_ready, 1);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1, t2, t3, t4, t33, nticks;

        no_div    = make_div(0, 0);
        reset     = 1'b1;
        en        = 1'b0;
        resync    = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_frac  = '0;

        // Default 4/0: ticks every 4 cycles, mid at 32, bit at 64.
        $display("[TB] default divisor 4/0");
        resetDut();
        for (int c = 1; c <= 64; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, no_div);
            checkOutput("def os_tick", os_tick, (c % 4 == 0));
            checkOutput("def mid_tick", mid_tick, (c == 32));
            checkOutput("def bit_tick", bit_tick, (c == 64));
        end

        // Fractional 13/8 loaded while frozen: periods 13,13,14,13,14...
        $display("[TB] fractional divisor 13/8");
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b1, make_div(13, 8));
        checkOutput("frac ready on transfer", cfg_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, no_div);
        checkOutput("frac ready pend", cfg_ready, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, no_div);
        checkOutput("frac ready after apply", cfg_ready, 1);
        cyc = 0;
        t1 = 0; t2 = 0; t3 = 0; t4 = 0; t33 = 0; nticks = 0;
        for (int c = 1; c <= 460; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, no_div);
            if (os_tick) begin
                nticks++;
                if (nticks == 1)  t1  = c;
                if (nticks == 2)  t2  = c;
                if (nticks == 3)  t3  = c;
                if (nticks == 4)  t4  = c;
                if (nticks == 33) t33 = c;
            end
        end
        checkOutput("frac tick1 cycle", t1, 13);
        checkOutput("frac tick2 cycle", t2, 26);
        checkOutput("frac tick3 cycle", t3, 40);
        checkOutput("frac tick4 cycle", t4, 53);
        checkOutput("frac span 1..33", t33 - t1, 432);
        checkOutput("frac tick count", nticks, 34);

        // Reconfigure to 6/0 mid-period while running at 4/0.
        $display("[TB] live reconfiguration to 6/0");
        resetDut();
        for (int c = 1; c <= 22; c++) begin
            applyStimulus(1'b1, 1'b0, (c == 2), make_div(6, 0));
            checkOutput("cfg os_tick", os_tick,
                        (c == 4 || c == 10 || c == 16 || c == 22));
            checkOutput("cfg cfg_ready", cfg_ready, (c <= 2 || c >= 5));
        end

        // Resync in cycle 10 at 4/0.
        $display("[TB] resync at cycle 10");
        resetDut();
        for (int c = 1; c <= 74; c++) begin
            applyStimulus(1'b1, (c == 10), 1'b0, no_div);
            checkOutput("rsy os_tick", os_tick,
                        (c == 4 || c == 8 || (c >= 14 && (c - 14) % 4 == 0)));
            checkOutput("rsy mid_tick", mid_tick, (c == 42));
            checkOutput("rsy bit_tick", bit_tick, (c == 74));
        end

        // en low for cycles 6..20 at 4/0.
        $display("[TB] enable gap cycles 6-20");
        resetDut();
        for (int c = 1; c <= 27; c++) begin
            applyStimulus(!(c >= 6 && c <= 20), 1'b0, 1'b0, no_div);
            checkOutput("en os_tick", os_tick, (c == 4 || c == 23 || c == 27));
        end

        // Zero divisor: tick every cycle, then reset mid-run.
        $display("[TB] zero divisor and mid-run reset");
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b1, make_div(0, 0));
        applyStimulus(1'b0, 1'b0, 1'b0, no_div);
        applyStimulus(1'b0, 1'b0, 1'b0, no_div);
        checkOutput("zero ready after apply", cfg_ready, 1);
        cyc = 0;
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, no_div);
            checkOutput("zero os_tick", os_tick, 1);
            checkOutput("zero mid_tick", mid_tick, (c == 8));
            checkOutput("zero bit_tick", bit_tick, (c == 16));
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst os_tick", os_tick, 0);
        checkOutput("midrst mid_tick", mid_tick, 0);
        checkOutput("midrst bit_tick", bit_tick, 0);
        checkOutput("midrst cfg_ready", cfg_ready, 1);
        reset = 1'b0;
        cyc   = 1;
        #1;
        checkOutput("post-rst os_tick", os_tick, 0);
        for (int c = 2; c <= 12; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, no_div);
            checkOutput("post-rst os_tick", os_tick, (c % 4 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
